// File: rtl/vc16_mem_pkg.sv
// rtl/vc16_mem_pkg.sv - shared state/kind types and load steering for mem_responder
package vc16_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        IO_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FETCH,
        LOAD,
        STORE
    } kind_t;

    localparam int LANE_LO = 0;
    localparam int LANE_HI = 1;

    // A single requested lane always comes back in the low byte, zero-filled above.
    function automatic logic [15:0] steer_load(input logic [1:0] lanes,
                                               input logic [7:0] hi,
                                               input logic [7:0] lo);
        case (lanes)
            2'b11:   steer_load = {hi, lo};
            2'b10:   steer_load = {8'h00, hi};
            default: steer_load = {8'h00, lo};
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - per-beat SRAM wait-state down-counter
module mem_wait_ctr #(
    parameter int WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic last_cycle
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    logic [2:0] count;

    // Reloaded whenever outside a beat or at a beat's last cycle, so every beat starts at WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= WAIT_CNT;
        end else if (load) begin
            count <= WAIT_CNT;
        end else if (count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    assign last_cycle = (count == 3'd0);

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request-bus responder for byte-wide SRAM and 16-bit I/O space
import vc16_mem_pkg::*;

module mem_responder #(
    parameter int RV   = 16,
    parameter int VA   = 16,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [VA-1:1] addr,
    input  logic          ifetch,
    input  logic [1:0]    rstrobe,
    input  logic [1:0]    wmask,
    input  logic [RV-1:0] wdata,
    input  logic          io_access,
    output logic          idone,
    output logic          rdone,
    output logic          wdone,
    output logic [RV-1:0] rdata,
    output logic [VA-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          mem_cs,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [VA-1:1] io_addr,
    output logic [RV-1:0] io_wdata,
    output logic [1:0]    io_wmask,
    output logic          io_re,
    output logic          io_we,
    input  logic [RV-1:0] io_rdata,
    input  logic          io_ready
);

    state_t        state;
    kind_t         kind_q;
    logic [VA-1:1] addr_q;
    logic [1:0]    lanes_q;
    logic [7:0]    whi_q;
    logic [7:0]    lo_q;
    logic          in_beat;
    logic          last_cycle;
    logic          abort;
    logic [2:0]    done_sel;

    assign in_beat  = state inside {RD_LO, RD_HI, WR_LO, WR_HI};
    assign abort    = (kind_q == FETCH) ? !ifetch : (rstrobe == 2'b00);
    assign done_sel = {kind_q == FETCH, kind_q == LOAD, kind_q == STORE};

    mem_wait_ctr #(.WAIT(WAIT)) u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (!in_beat || last_cycle),
        .last_cycle (last_cycle)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            kind_q    <= FETCH;
            addr_q    <= '0;
            lanes_q   <= 2'b00;
            whi_q     <= 8'h00;
            lo_q      <= 8'h00;
            idone     <= 1'b0;
            rdone     <= 1'b0;
            wdone     <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
            io_wmask  <= 2'b00;
            io_re     <= 1'b0;
            io_we     <= 1'b0;
        end else begin
            {idone, rdone, wdone} <= 3'b000;
            case (state)
                IDLE: begin
                    addr_q <= addr;
                    whi_q  <= wdata[15:8];
                    if (|wmask) begin
                        kind_q  <= STORE;
                        lanes_q <= wmask;
                        if (io_access) begin
                            state    <= IO_WAIT;
                            io_we    <= 1'b1;
                            io_addr  <= addr;
                            io_wdata <= wdata;
                            io_wmask <= wmask;
                        end else begin
                            mem_cs <= 1'b1;
                            mem_we <= 1'b1;
                            if (wmask[LANE_LO]) begin
                                state     <= WR_LO;
                                mem_addr  <= {addr, 1'b0};
                                mem_wdata <= wdata[7:0];
                            end else begin
                                state     <= WR_HI;
                                mem_addr  <= {addr, 1'b1};
                                mem_wdata <= wdata[15:8];
                            end
                        end
                    end else if (|rstrobe) begin
                        kind_q  <= LOAD;
                        lanes_q <= rstrobe;
                        if (io_access) begin
                            state    <= IO_WAIT;
                            io_re    <= 1'b1;
                            io_addr  <= addr;
                            io_wmask <= wmask;
                        end else begin
                            mem_cs <= 1'b1;
                            mem_oe <= 1'b1;
                            if (rstrobe[LANE_LO]) begin
                                state    <= RD_LO;
                                mem_addr <= {addr, 1'b0};
                            end else begin
                                state    <= RD_HI;
                                mem_addr <= {addr, 1'b1};
                            end
                        end
                    end else if (ifetch) begin
                        kind_q   <= FETCH;
                        lanes_q  <= 2'b11;
                        state    <= RD_LO;
                        mem_cs   <= 1'b1;
                        mem_oe   <= 1'b1;
                        mem_addr <= {addr, 1'b0};
                    end
                end
                RD_LO: begin
                    if (abort) begin
                        state  <= IDLE;
                        mem_cs <= 1'b0;
                        mem_oe <= 1'b0;
                    end else if (last_cycle) begin
                        lo_q <= mem_rdata;
                        if (lanes_q[LANE_HI]) begin
                            state    <= RD_HI;
                            mem_addr <= {addr_q, 1'b1};
                        end else begin
                            state                 <= DONE;
                            mem_cs                <= 1'b0;
                            mem_oe                <= 1'b0;
                            rdata                 <= steer_load(lanes_q, 8'h00, mem_rdata);
                            {idone, rdone, wdone} <= done_sel;
                        end
                    end
                end
                RD_HI: begin
                    if (abort) begin
                        state  <= IDLE;
                        mem_cs <= 1'b0;
                        mem_oe <= 1'b0;
                    end else if (last_cycle) begin
                        state                 <= DONE;
                        mem_cs                <= 1'b0;
                        mem_oe                <= 1'b0;
                        rdata                 <= steer_load(lanes_q, mem_rdata, lo_q);
                        {idone, rdone, wdone} <= done_sel;
                    end
                end
                WR_LO: begin
                    if (last_cycle) begin
                        if (lanes_q[LANE_HI]) begin
                            state     <= WR_HI;
                            mem_addr  <= {addr_q, 1'b1};
                            mem_wdata <= whi_q;
                        end else begin
                            state                 <= DONE;
                            mem_cs                <= 1'b0;
                            mem_we                <= 1'b0;
                            {idone, rdone, wdone} <= done_sel;
                        end
                    end
                end
                WR_HI: begin
                    if (last_cycle) begin
                        state                 <= DONE;
                        mem_cs                <= 1'b0;
                        mem_we                <= 1'b0;
                        {idone, rdone, wdone} <= done_sel;
                    end
                end
                IO_WAIT: begin
                    if (io_ready) begin
                        state                 <= DONE;
                        io_re                 <= 1'b0;
                        io_we                 <= 1'b0;
                        {idone, rdone, wdone} <= done_sel;
                        if (kind_q == LOAD) begin
                            rdata <= steer_load(lanes_q, io_rdata[15:8], io_rdata[7:0]);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [14:0] addr      [2];
    logic        ifetch    [2];
    logic [1:0]  rstrobe   [2];
    logic [1:0]  wmask     [2];
    logic [15:0] wdata     [2];
    logic        io_access [2];
    logic        idone     [2];
    logic        rdone     [2];
    logic        wdone     [2];
    logic [15:0] rdata     [2];
    logic [15:0] mem_addr  [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];
    logic        mem_cs    [2];
    logic        mem_oe    [2];
    logic        mem_we    [2];
    logic [14:0] io_addr   [2];
    logic [15:0] io_wdata  [2];
    logic [1:0]  io_wmask  [2];
    logic        io_re     [2];
    logic        io_we     [2];
    logic [15:0] io_rdata  [2];
    logic        io_ready  [2];

    logic [7:0]  sram [0:255];
    logic        init_mem;
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [7:0]  bd_data;

    int          checks;
    int          errors;
    logic [15:0] last_rd [2];

    logic [15:0] beat_addrs [$];
    int          we_lo_cnt, we_hi_cnt, we_bad, overlap, io_act;
    logic [14:0] seen_io_addr;
    logic [15:0] seen_io_wdata;
    logic [1:0]  seen_io_wmask;

    mem_responder #(.RV(16), .VA(16), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .addr(addr[0]), .ifetch(ifetch[0]), .rstrobe(rstrobe[0]),
        .wmask(wmask[0]), .wdata(wdata[0]), .io_access(io_access[0]),
        .idone(idone[0]), .rdone(rdone[0]), .wdone(wdone[0]), .rdata(rdata[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .mem_cs(mem_cs[0]), .mem_oe(mem_oe[0]), .mem_we(mem_we[0]),
        .io_addr(io_addr[0]), .io_wdata(io_wdata[0]), .io_wmask(io_wmask[0]),
        .io_re(io_re[0]), .io_we(io_we[0]), .io_rdata(io_rdata[0]), .io_ready(io_ready[0])
    );

    mem_responder #(.RV(16), .VA(16), .WAIT(2)) dut1 (
        .clk(clk), .reset(reset), .addr(addr[1]), .ifetch(ifetch[1]), .rstrobe(rstrobe[1]),
        .wmask(wmask[1]), .wdata(wdata[1]), .io_access(io_access[1]),
        .idone(idone[1]), .rdone(rdone[1]), .wdone(wdone[1]), .rdata(rdata[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .mem_cs(mem_cs[1]), .mem_oe(mem_oe[1]), .mem_we(mem_we[1]),
        .io_addr(io_addr[1]), .io_wdata(io_wdata[1]), .io_wmask(io_wmask[1]),
        .io_re(io_re[1]), .io_we(io_we[1]), .io_rdata(io_rdata[1]), .io_ready(io_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata[0] = sram[mem_addr[0][7:0]];
    assign mem_rdata[1] = sram[mem_addr[1][7:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) sram[i] <= 8'(i * 7 + 3);
        end else if (bd_we) begin
            sram[bd_addr] <= bd_data;
        end
        for (int k = 0; k < 2; k++) begin
            if (mem_we[k] && mem_cs[k]) sram[mem_addr[k][7:0]] <= mem_wdata[k];
        end
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic [15:0] exp_load(input logic [1:0] ln, input logic [15:0] w);
        if (ln == 2'b11) return w;
        else if (ln == 2'b01) return {8'h00, w[7:0]};
        else return {8'h00, w[15:8]};
    endfunction

    function automatic logic [80:0] all_outs(input int d);
        return {idone[d], rdone[d], wdone[d], rdata[d], mem_addr[d], mem_wdata[d],
                mem_cs[d], mem_oe[d], mem_we[d], io_addr[d], io_wdata[d], io_wmask[d],
                io_re[d], io_we[d]};
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        bd_addr = a;
        bd_data = v;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // kind: 0 fetch, 1 load, 2 store. Drives a held request and plays the SRAM/I/O peer.
    task automatic run_req(input int d, input int kind, input logic [14:0] a, input logic [1:0] ln,
                           input logic [15:0] wd, input logic io, input int io_lat,
                           input logic [15:0] io_rd, output int cyc, output logic [2:0] dn,
                           output logic [15:0] rd);
        int io_n;
        cyc = -1; dn = 3'b000; rd = 16'h0000; io_n = 0;
        beat_addrs.delete();
        we_lo_cnt = 0; we_hi_cnt = 0; we_bad = 0; overlap = 0; io_act = 0;
        seen_io_addr = '0; seen_io_wdata = '0; seen_io_wmask = '0;
        @(negedge clk);
        addr[d] = a; wdata[d] = wd; io_access[d] = io;
        if (kind == 0) ifetch[d] = 1'b1;
        else if (kind == 1) rstrobe[d] = ln;
        else wmask[d] = ln;
        for (int c = 1; c <= 60 && cyc < 0; c++) begin
            @(negedge clk);
            io_ready[d] = 1'b0;
            if (mem_we[d] && mem_oe[d]) overlap++;
            if (mem_we[d]) begin
                if (mem_addr[d][0]) we_hi_cnt++; else we_lo_cnt++;
                if (mem_wdata[d] !== (mem_addr[d][0] ? wd[15:8] : wd[7:0])) we_bad++;
            end
            if (mem_cs[d] && (beat_addrs.size() == 0 || beat_addrs[$] != mem_addr[d]))
                beat_addrs.push_back(mem_addr[d]);
            if (io_re[d] || io_we[d]) begin
                io_act++;
                io_n++;
                seen_io_addr = io_addr[d]; seen_io_wdata = io_wdata[d]; seen_io_wmask = io_wmask[d];
                if (io_n == io_lat) begin
                    io_ready[d] = 1'b1;
                    io_rdata[d] = io_rd;
                end
            end
            if (idone[d] || rdone[d] || wdone[d]) begin
                cyc = c;
                dn  = {idone[d], rdone[d], wdone[d]};
                rd  = rdata[d];
            end
        end
        ifetch[d] = 1'b0; rstrobe[d] = 2'b00; wmask[d] = 2'b00; io_access[d] = 1'b0;
    endtask

    task automatic test_reset();
        init_mem = 1'b1;
        @(posedge clk);
        #1 init_mem = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (all_outs(d) !== '0) begin
                errors++;
                $display("FAIL reset_outs dut%0d got %h exp 0", d, all_outs(d));
            end
            last_rd[d] = 16'h0000;
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_word();
        int cyc; logic [2:0] dn; logic [15:0] rd;
        poke(8'h20, 8'h34);
        poke(8'h21, 8'h12);
        run_req(0, 0, 15'h0010, 2'b11, 16'h0, 1'b0, 0, 16'h0, cyc, dn, rd);
        checks++;
        if (cyc != 3) begin errors++; $display("FAIL fetch_latency got %0d exp 3", cyc); end
        checks++;
        if (dn !== 3'b100) begin errors++; $display("FAIL fetch_done got %b exp 100", dn); end
        checks++;
        if (rd !== 16'h1234) begin errors++; $display("FAIL fetch_rdata got %h exp 1234", rd); end
        checks++;
        if (beat_addrs.size() != 2 || beat_addrs[0] !== 16'h0020 || beat_addrs[1] !== 16'h0021) begin
            errors++;
            $display("FAIL fetch_addrs got %p exp 0020,0021", beat_addrs);
        end
        last_rd[0] = 16'h1234;
    endtask

    task automatic test_odd_byte();
        int cyc; logic [2:0] dn; logic [15:0] rd;
        poke(8'h21, 8'h9A);
        run_req(0, 1, 15'h0010, 2'b10, 16'h0, 1'b0, 0, 16'h0, cyc, dn, rd);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL odd_latency got %0d exp 2", cyc); end
        checks++;
        if (rd !== 16'h009A || dn !== 3'b010) begin
            errors++;
            $display("FAIL odd_rdata got %h/%b exp 009a/010", rd, dn);
        end
        checks++;
        if (beat_addrs.size() != 1 || beat_addrs[0] !== 16'h0021) begin
            errors++;
            $display("FAIL odd_addrs got %p exp 0021", beat_addrs);
        end
        last_rd[0] = 16'h009A;
    endtask

    task automatic test_store_wait2();
        int cyc; logic [2:0] dn; logic [15:0] rd;
        run_req(1, 2, 15'h0040, 2'b11, 16'hBEEF, 1'b0, 0, 16'h0, cyc, dn, rd);
        checks++;
        if (cyc != 7 || dn !== 3'b001) begin
            errors++;
            $display("FAIL store_done got %0d/%b exp 7/001", cyc, dn);
        end
        checks++;
        if (we_lo_cnt != 3 || we_hi_cnt != 3 || we_bad != 0) begin
            errors++;
            $display("FAIL store_beats got lo=%0d hi=%0d bad=%0d exp 3 3 0", we_lo_cnt, we_hi_cnt, we_bad);
        end
        checks++;
        if (beat_addrs.size() != 2 || beat_addrs[0] !== 16'h0080 || beat_addrs[1] !== 16'h0081) begin
            errors++;
            $display("FAIL store_addrs got %p exp 0080,0081", beat_addrs);
        end
        @(negedge clk);
        checks++;
        if (sram[8'h80] !== 8'hEF || sram[8'h81] !== 8'hBE) begin
            errors++;
            $display("FAIL store_mem got %h%h exp beef", sram[8'h81], sram[8'h80]);
        end
        checks++;
        if (rd !== last_rd[1]) begin errors++; $display("FAIL store_rdata_hold got %h exp %h", rd, last_rd[1]); end
    endtask

    task automatic test_io_load();
        int cyc; logic [2:0] dn; logic [15:0] rd;
        run_req(0, 1, 15'h0005, 2'b11, 16'h0, 1'b1, 4, 16'h5A5A, cyc, dn, rd);
        checks++;
        if (io_act != 4) begin errors++; $display("FAIL io_re_cycles got %0d exp 4", io_act); end
        checks++;
        if (cyc != 5 || dn !== 3'b010) begin
            errors++;
            $display("FAIL io_done got %0d/%b exp 5/010", cyc, dn);
        end
        checks++;
        if (rd !== 16'h5A5A) begin errors++; $display("FAIL io_rdata got %h exp 5a5a", rd); end
        checks++;
        if (seen_io_addr !== 15'h0005 || seen_io_wmask !== 2'b00 || beat_addrs.size() != 0) begin
            errors++;
            $display("FAIL io_port got addr=%h mask=%b beats=%0d exp 0005 00 0",
                     seen_io_addr, seen_io_wmask, beat_addrs.size());
        end
        last_rd[0] = 16'h5A5A;
    endtask

    task automatic test_simultaneous();
        int cw, ci, n;
        logic [7:0]  hi;
        logic [15:0] rd;
        cw = -1; ci = -1; n = 0; rd = 16'h0;
        hi = sram[8'h61];
        @(negedge clk);
        addr[0] = 15'h0030; wdata[0] = 16'h1177; wmask[0] = 2'b01; ifetch[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            n += int'(idone[0]) + int'(rdone[0]) + int'(wdone[0]);
            if (wdone[0]) begin cw = c; wmask[0] = 2'b00; end
            if (idone[0]) begin ci = c; rd = rdata[0]; ifetch[0] = 1'b0; end
        end
        ifetch[0] = 1'b0; wmask[0] = 2'b00;
        checks++;
        if (cw != 2) begin errors++; $display("FAIL simul_store_first got %0d exp 2", cw); end
        checks++;
        if (ci != 6) begin errors++; $display("FAIL simul_fetch_after got %0d exp 6", ci); end
        checks++;
        if (n != 2) begin errors++; $display("FAIL simul_done_count got %0d exp 2", n); end
        checks++;
        if (rd !== {hi, 8'h77}) begin errors++; $display("FAIL simul_rdata got %h exp %h", rd, {hi, 8'h77}); end
        last_rd[0] = {hi, 8'h77};
    endtask

    task automatic test_abort();
        int n;
        n = 0;
        @(negedge clk);
        addr[1] = 15'h0022; ifetch[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ifetch[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_cs[1] !== 1'b0 || mem_oe[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_release got cs=%b oe=%b exp 0 0", mem_cs[1], mem_oe[1]);
        end
        repeat (8) begin
            @(negedge clk);
            n += int'(idone[1]) + int'(rdone[1]) + int'(wdone[1]);
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", n); end
        checks++;
        if (rdata[1] !== last_rd[1]) begin errors++; $display("FAIL abort_rdata got %h exp %h", rdata[1], last_rd[1]); end
    endtask

    task automatic test_reset_mid();
        int cyc; logic [2:0] dn; logic [15:0] rd; logic [15:0] exp_w;
        @(negedge clk);
        addr[0] = 15'h0011; ifetch[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr[0] !== 16'h0023 || mem_oe[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_hi got %h/%b exp 0023/1", mem_addr[0], mem_oe[0]);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs(0) !== '0) begin errors++; $display("FAIL rst_mid_outs got %h exp 0", all_outs(0)); end
        reset = 1'b1; ifetch[0] = 1'b0;
        last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
        @(negedge clk);
        exp_w = {sram[8'h23], sram[8'h22]};
        run_req(0, 0, 15'h0011, 2'b11, 16'h0, 1'b0, 0, 16'h0, cyc, dn, rd);
        checks++;
        if (cyc != 3 || dn !== 3'b100 || rd !== exp_w) begin
            errors++;
            $display("FAIL rst_mid_refetch got %0d/%b/%h exp 3/100/%h", cyc, dn, rd, exp_w);
        end
        last_rd[0] = exp_w;
    endtask

    task automatic test_random();
        int d, kind, io_lat, cyc, exp_cyc, nl;
        logic [1:0] ln, eff; logic [14:0] a; logic [15:0] wd, io_rd, rd, old_w, exp_rd;
        logic [2:0] dn, exp_dn; logic io, io_path;
        for (int it = 0; it < 40; it++) begin
            d      = int'($urandom_range(0, 1));
            kind   = int'($urandom_range(0, 2));
            ln     = 2'($urandom_range(1, 3));
            a      = 15'($urandom_range(0, 127));
            wd     = 16'($urandom);
            io_rd  = 16'($urandom);
            io     = ($urandom_range(0, 3) == 0);
            io_lat = int'($urandom_range(1, 5));
            eff     = (kind == 0) ? 2'b11 : ln;
            io_path = io && (kind != 0);
            nl      = int'(eff[0]) + int'(eff[1]);
            old_w   = {sram[{a[6:0], 1'b1}], sram[{a[6:0], 1'b0}]};
            exp_cyc = io_path ? 1 + io_lat : 1 + nl * (wait_of(d) + 1);
            exp_dn  = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;
            if (kind == 2) exp_rd = last_rd[d];
            else exp_rd = exp_load(eff, io_path ? io_rd : old_w);
            run_req(d, kind, a, ln, wd, io, io_lat, io_rd, cyc, dn, rd);
            @(negedge clk);
            checks++;
            if (cyc != exp_cyc) begin errors++; $display("FAIL rnd_latency it=%0d got %0d exp %0d", it, cyc, exp_cyc); end
            checks++;
            if (dn !== exp_dn) begin errors++; $display("FAIL rnd_done it=%0d got %b exp %b", it, dn, exp_dn); end
            checks++;
            if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata it=%0d got %h exp %h", it, rd, exp_rd); end
            checks++;
            if (overlap != 0) begin errors++; $display("FAIL rnd_we_oe it=%0d got %0d exp 0", it, overlap); end
            checks++;
            if (io_act != (io_path ? io_lat : 0)) begin
                errors++;
                $display("FAIL rnd_io_cycles it=%0d got %0d exp %0d", it, io_act, io_path ? io_lat : 0);
            end
            if (kind == 2) begin
                checks++;
                if (we_bad != 0 || (we_lo_cnt + we_hi_cnt) != (io_path ? 0 : nl * (wait_of(d) + 1))) begin
                    errors++;
                    $display("FAIL rnd_we_beats it=%0d got %0d bad=%0d", it, we_lo_cnt + we_hi_cnt, we_bad);
                end
                checks++;
                if ({sram[{a[6:0], 1'b1}], sram[{a[6:0], 1'b0}]} !==
                    {(ln[1] && !io_path) ? wd[15:8] : old_w[15:8], (ln[0] && !io_path) ? wd[7:0] : old_w[7:0]}) begin
                    errors++;
                    $display("FAIL rnd_mem it=%0d got %h%h old %h wd %h", it,
                             sram[{a[6:0], 1'b1}], sram[{a[6:0], 1'b0}], old_w, wd);
                end
                if (io_path) begin
                    checks++;
                    if (seen_io_addr !== a || seen_io_wdata !== wd || seen_io_wmask !== ln) begin
                        errors++;
                        $display("FAIL rnd_io_store it=%0d got %h/%h/%b exp %h/%h/%b", it,
                                 seen_io_addr, seen_io_wdata, seen_io_wmask, a, wd, ln);
                    end
                end
            end else begin
                last_rd[d] = exp_rd;
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; init_mem = 1'b0; bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; ifetch[d] = 1'b0; rstrobe[d] = 2'b00; wmask[d] = 2'b00;
            wdata[d] = '0; io_access[d] = 1'b0; io_rdata[d] = '0; io_ready[d] = 1'b0;
            last_rd[d] = '0;
        end
        test_reset();
        test_fetch_word();
        test_odd_byte();
        test_store_wait2();
        test_io_load();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
